// File: rtl/hazard_ctrl_pkg.sv
// Shared widths and flush FSM state encodings for the hazard controller.
package hazard_ctrl_pkg;

   localparam int REG_IDX_WIDTH = 5;
   localparam int SB_CNT_WIDTH  = 2;
   localparam int NUM_REGS      = 1 << REG_IDX_WIDTH;
   localparam int FCNT_WIDTH    = 3;

   typedef enum logic {
      HZ_ST_RUN   = 1'b0,
      HZ_ST_FLUSH = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register counters of outstanding writes, with a sticky underflow flag.
module hz_scoreboard
   import hazard_ctrl_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     inc_en_i,
   input  logic [REG_IDX_WIDTH-1:0] inc_idx_i,
   input  logic                     dec0_en_i,
   input  logic [REG_IDX_WIDTH-1:0] dec0_idx_i,
   input  logic                     dec1_en_i,
   input  logic [REG_IDX_WIDTH-1:0] dec1_idx_i,
   input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
   input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
   input  logic [REG_IDX_WIDTH-1:0] rd_idx_i,
   output logic [SB_CNT_WIDTH-1:0]  rs1_cnt_o,
   output logic [SB_CNT_WIDTH-1:0]  rs2_cnt_o,
   output logic [SB_CNT_WIDTH-1:0]  rd_cnt_o,
   output logic                     err_o
);

   logic [SB_CNT_WIDTH-1:0] cnt_q [NUM_REGS];
   logic [SB_CNT_WIDTH-1:0] cnt_d [NUM_REGS];
   logic                    err_q;
   logic                    err_d;

   // Net increment and decrements per register; excess decrements are dropped and flagged.
   always_comb begin : next_cnt
      logic [SB_CNT_WIDTH:0] total;
      logic [SB_CNT_WIDTH:0] dec_cnt;
      logic [SB_CNT_WIDTH:0] diff;
      err_d    = err_q;
      cnt_d[0] = '0;
      total    = '0;
      dec_cnt  = '0;
      diff     = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         total   = {1'b0, cnt_q[r]}
                 + {{SB_CNT_WIDTH{1'b0}}, (inc_en_i && (inc_idx_i == REG_IDX_WIDTH'(r)))};
         dec_cnt = {{SB_CNT_WIDTH{1'b0}}, (dec0_en_i && (dec0_idx_i == REG_IDX_WIDTH'(r)))}
                 + {{SB_CNT_WIDTH{1'b0}}, (dec1_en_i && (dec1_idx_i == REG_IDX_WIDTH'(r)))};
         diff    = total - dec_cnt;
         if (dec_cnt > total) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else if (diff > {1'b0, {SB_CNT_WIDTH{1'b1}}}) begin
            cnt_d[r] = {SB_CNT_WIDTH{1'b1}};
         end else begin
            cnt_d[r] = diff[SB_CNT_WIDTH-1:0];
         end
      end
   end

   // Counter and sticky error registers; reset discards all pending counts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign rs1_cnt_o = cnt_q[rs1_idx_i];
   assign rs2_cnt_o = cnt_q[rs2_idx_i];
   assign rd_cnt_o  = cnt_q[rd_idx_i];
   assign err_o     = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard detection (RAW, write overflow, downstream busy) and redirect flush sequencing.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MAX_INFLIGHT = 3,
   parameter int FLUSH_EXTRA  = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     dec_valid_i,
   input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
   input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
   input  logic                     dec_rs1_en_i,
   input  logic                     dec_rs2_en_i,
   input  logic [REG_IDX_WIDTH-1:0] dec_rd_idx_i,
   input  logic                     dec_rd_en_i,
   input  logic                     ex_busy_i,
   input  logic                     redirect_i,
   input  logic                     wb_en_i,
   input  logic [REG_IDX_WIDTH-1:0] wb_idx_i,
   input  logic                     cancel_en_i,
   input  logic [REG_IDX_WIDTH-1:0] cancel_idx_i,
   output logic                     stall_o,
   output logic                     issue_o,
   output logic                     flush_o,
   output logic                     sb_err_o
);

   localparam logic                  FLUSH_EN   = (FLUSH_EXTRA > 0);
   localparam logic [FCNT_WIDTH-1:0] FLUSH_LOAD = FCNT_WIDTH'(FLUSH_EXTRA);
   localparam logic [SB_CNT_WIDTH-1:0] CNT_MAX  = SB_CNT_WIDTH'(MAX_INFLIGHT);

   hz_state_e               state_q;
   hz_state_e               state_d;
   logic [FCNT_WIDTH-1:0]   fcnt_q;
   logic [FCNT_WIDTH-1:0]   fcnt_d;
   logic [SB_CNT_WIDTH-1:0] rs1_cnt;
   logic [SB_CNT_WIDTH-1:0] rs2_cnt;
   logic [SB_CNT_WIDTH-1:0] rd_cnt;
   logic                    raw;
   logic                    ovf;
   logic                    inc_en;

   hz_scoreboard u_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_en_i   (inc_en),
      .inc_idx_i  (dec_rd_idx_i),
      .dec0_en_i  (wb_en_i),
      .dec0_idx_i (wb_idx_i),
      .dec1_en_i  (cancel_en_i),
      .dec1_idx_i (cancel_idx_i),
      .rs1_idx_i  (dec_rs1_idx_i),
      .rs2_idx_i  (dec_rs2_idx_i),
      .rd_idx_i   (dec_rd_idx_i),
      .rs1_cnt_o  (rs1_cnt),
      .rs2_cnt_o  (rs2_cnt),
      .rd_cnt_o   (rd_cnt),
      .err_o      (sb_err_o)
   );

   // Hazard, flush and issue decisions; a flush masks both stall and issue.
   always_comb begin
      raw     = (dec_rs1_en_i && (rs1_cnt != '0)) || (dec_rs2_en_i && (rs2_cnt != '0));
      ovf     = dec_rd_en_i && (dec_rd_idx_i != '0) && (rd_cnt == CNT_MAX);
      flush_o = redirect_i || (state_q == HZ_ST_FLUSH);
      stall_o = dec_valid_i && !flush_o && (raw || ovf || ex_busy_i);
      issue_o = dec_valid_i && !flush_o && !stall_o;
      inc_en  = issue_o && dec_rd_en_i && (dec_rd_idx_i != '0);
   end

   // Flush sequencer next state: a redirect (re)loads the extra-cycle count.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         HZ_ST_RUN: begin
            if (redirect_i && FLUSH_EN) begin
               state_d = HZ_ST_FLUSH;
               fcnt_d  = FLUSH_LOAD;
            end
         end
         HZ_ST_FLUSH: begin
            if (redirect_i) begin
               fcnt_d = FLUSH_LOAD;
            end else if (fcnt_q <= FCNT_WIDTH'(1)) begin
               state_d = HZ_ST_RUN;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q - FCNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = HZ_ST_RUN;
            fcnt_d  = '0;
         end
      endcase
   end

   // Flush sequencer state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= HZ_ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

endmodule
